dsqw_job_ctrl: RTL and testbench

Job sequencer for the deskew IP. It accepts a start command with a frame configuration, validates the frame size, and issues one line request per image row to the line-copy engine. It supervises every line for bus errors and timeouts, and raises the single-cycle event pulses that the IRQ controller latches as sticky interrupts: `dsqw_done`, `err_size` and `mem_acc_err`.

---
 rtl/dsqw_pkg.sv | 21 ++
 rtl/dsqw_line_tmo.sv | 28 ++
 rtl/dsqw_job_ctrl.sv | 124 ++++++++++++
 tb/tb_dsqw_job_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsqw_pkg.sv
// Shared deskew IP definitions: default geometry/bus widths and the job FSM encoding.
package dsqw_pkg;

  localparam int unsigned DSQW_DIM_W      = 12;
  localparam int unsigned DSQW_ADDR_W     = 32;
  localparam int unsigned DSQW_MAX_WIDTH  = 2048;
  localparam int unsigned DSQW_MAX_HEIGHT = 2048;
  localparam int unsigned DSQW_TMO_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_REQ      = 3'd2,
    ST_WAIT     = 3'd3,
    ST_NEXT     = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR_SIZE = 3'd6,
    ST_ERR_MEM  = 3'd7
  } dsqw_state_e;

endpackage

// File: rtl/dsqw_line_tmo.sv
// Per-line watchdog: counts cycles while enabled and flags the last allowed cycle.
module dsqw_line_tmo #(
  parameter int unsigned TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  // A zero limit disables the watchdog entirely.
  assign expired = en && (limit != '0) && (cnt == limit - TMO_W'(1));

endmodule

// File: rtl/dsqw_job_ctrl.sv
// Deskew job sequencer: validates the frame, issues one line request per row and
// reports completion, size faults and memory access faults as one-cycle pulses.
module dsqw_job_ctrl
  import dsqw_pkg::*;
#(
  parameter int unsigned DIM_W      = DSQW_DIM_W,
  parameter int unsigned ADDR_W     = DSQW_ADDR_W,
  parameter int unsigned MAX_WIDTH  = DSQW_MAX_WIDTH,
  parameter int unsigned MAX_HEIGHT = DSQW_MAX_HEIGHT,
  parameter int unsigned TMO_W      = DSQW_TMO_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [DIM_W-1:0]  cfg_stride,
  input  logic [ADDR_W-1:0] cfg_src_base,
  input  logic [ADDR_W-1:0] cfg_dst_base,
  input  logic [TMO_W-1:0]  cfg_timeout,
  output logic              busy,
  output logic              line_req,
  output logic [ADDR_W-1:0] line_src_addr,
  output logic [ADDR_W-1:0] line_dst_addr,
  output logic [DIM_W-1:0]  line_len,
  input  logic              line_ack,
  input  logic              line_done,
  input  logic              line_err,
  output logic              dsqw_done,
  output logic              err_size,
  output logic              mem_acc_err
);

  localparam logic [DIM_W-1:0] MAX_W = DIM_W'(MAX_WIDTH);
  localparam logic [DIM_W-1:0] MAX_H = DIM_W'(MAX_HEIGHT);

  dsqw_state_e      state;
  dsqw_state_e      state_nxt;
  logic [DIM_W-1:0] height_q;
  logic [DIM_W-1:0] stride_q;
  logic [DIM_W-1:0] line_cnt;
  logic [TMO_W-1:0] tmo_q;
  logic             size_fault;
  logic             tmo_expired;

  // line_len doubles as the latched frame width.
  assign size_fault = (line_len == '0) || (height_q == '0) ||
                      (line_len > MAX_W) || (height_q > MAX_H) ||
                      (line_len > stride_q);

  dsqw_line_tmo #(.TMO_W(TMO_W)) u_line_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state != ST_WAIT),
    .en      (state == ST_WAIT),
    .limit   (tmo_q),
    .expired (tmo_expired)
  );

  // Next-state selection; abort overrides every other event.
  always_comb begin
    state_nxt = state;
    if ((state != ST_IDLE) && abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_CHECK;
        ST_CHECK: state_nxt = size_fault ? ST_ERR_SIZE : ST_REQ;
        ST_REQ:   if (line_ack) state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (line_err || tmo_expired) state_nxt = ST_ERR_MEM;
          else if (line_done)          state_nxt = ST_NEXT;
        end
        ST_NEXT:  state_nxt = (line_cnt == height_q - DIM_W'(1)) ? ST_DONE : ST_REQ;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, snapshot and outputs; outputs decode the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      line_req      <= 1'b0;
      dsqw_done     <= 1'b0;
      err_size      <= 1'b0;
      mem_acc_err   <= 1'b0;
      line_src_addr <= '0;
      line_dst_addr <= '0;
      line_len      <= '0;
      height_q      <= '0;
      stride_q      <= '0;
      tmo_q         <= '0;
      line_cnt      <= '0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != ST_IDLE);
      line_req    <= (state_nxt == ST_REQ);
      dsqw_done   <= (state_nxt == ST_DONE);
      err_size    <= (state_nxt == ST_ERR_SIZE);
      mem_acc_err <= (state_nxt == ST_ERR_MEM);

      if ((state == ST_IDLE) && start) begin
        line_len      <= cfg_width;
        height_q      <= cfg_height;
        stride_q      <= cfg_stride;
        tmo_q         <= cfg_timeout;
        line_src_addr <= cfg_src_base;
        line_dst_addr <= cfg_dst_base;
        line_cnt      <= '0;
      end

      // Address advance wraps silently at the top of the address space.
      if (state == ST_NEXT) begin
        line_cnt      <= line_cnt + DIM_W'(1);
        line_src_addr <= line_src_addr + ADDR_W'(stride_q);
        line_dst_addr <= line_dst_addr + ADDR_W'(stride_q);
      end
    end
  end

endmodule

// File: tb/tb_dsqw_job_ctrl.sv
// Self-checking bench for dsqw_job_ctrl: a scripted line engine plus a frame-level
// reference model (request list, outcome and cycle budget per job).
module tb_dsqw_job_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [11:0] cfg_width, cfg_height, cfg_stride;
  logic [31:0] cfg_src_base, cfg_dst_base;
  logic [15:0] cfg_timeout;
  logic        busy, line_req;
  logic [31:0] line_src_addr, line_dst_addr;
  logic [11:0] line_len;
  logic        line_ack, line_done, line_err;
  logic        dsqw_done, err_size, mem_acc_err;

  always #5 clk = ~clk;

  dsqw_job_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_stride(cfg_stride),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .cfg_timeout(cfg_timeout),
    .busy(busy), .line_req(line_req), .line_src_addr(line_src_addr),
    .line_dst_addr(line_dst_addr), .line_len(line_len), .line_ack(line_ack),
    .line_done(line_done), .line_err(line_err), .dsqw_done(dsqw_done),
    .err_size(err_size), .mem_acc_err(mem_acc_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] obs_src[$];
  logic [31:0] obs_dst[$];
  logic [11:0] obs_len[$];
  int n_done, n_esize, n_merr, n_req_cycles, n_unstable, n_b2b;
  int rel_done, rel_esize, rel_merr, rel_idle;
  bit job_timeout;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit exp_fault(int w, int h, int s);
    return (w == 0) || (h == 0) || (w > 2048) || (h > 2048) || (w > s);
  endfunction

  // Runs one job against a scripted engine (ack after a cycles, done/err after d
  // WAIT cycles) and records what the DUT did, relative to the start edge.
  task automatic run_job(input int w, input int h, input int s,
                         input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] tmo, input int a, input int d,
                         input int err_line, input int abort_rel, input int budget);
    int rel, phase, k, li, rel_wait;
    logic [31:0] cur_src, cur_dst;
    logic [11:0] cur_len;
    obs_src.delete(); obs_dst.delete(); obs_len.delete();
    n_done = 0; n_esize = 0; n_merr = 0; n_req_cycles = 0; n_unstable = 0; n_b2b = 0;
    rel_done = -1; rel_esize = -1; rel_merr = -1; rel_idle = -1; rel_wait = -1;
    job_timeout = 0;
    cur_src = '0; cur_dst = '0; cur_len = '0;
    cfg_width = 12'(w); cfg_height = 12'(h); cfg_stride = 12'(s);
    cfg_src_base = src; cfg_dst_base = dst; cfg_timeout = tmo;
    start = 1'b1;
    tick();
    start = 1'b0;
    rel = 0; phase = 0; k = 0; li = 0;
    while (1) begin
      if (dsqw_done)   begin n_done++;  rel_done  = rel; end
      if (err_size)    begin n_esize++; rel_esize = rel; end
      if (mem_acc_err) begin n_merr++;  rel_merr  = rel; end
      if (line_req) n_req_cycles++;
      if (!busy && rel_idle < 0) rel_idle = rel;
      if (rel_idle >= 0 && rel >= rel_idle + 3) break;
      if (rel >= budget) begin job_timeout = 1; break; end
      line_ack = 0; line_done = 0; line_err = 0; abort = 0; start = 0;
      if (phase == 2) begin
        if (rel == rel_wait && line_req) n_b2b++;
        if (k == 0) begin
          if (li == err_line) begin
            line_err = 1'b1;
            line_done = 1'($urandom_range(0, 1));
          end else begin
            line_done = 1'b1;
          end
          phase = 0;
          li++;
        end else begin
          k--;
        end
      end
      if (phase == 0 && line_req) begin
        obs_src.push_back(line_src_addr);
        obs_dst.push_back(line_dst_addr);
        obs_len.push_back(line_len);
        cur_src = line_src_addr; cur_dst = line_dst_addr; cur_len = line_len;
        phase = 1; k = a;
      end else if (phase == 1) begin
        if (!line_req || line_src_addr !== cur_src || line_dst_addr !== cur_dst ||
            line_len !== cur_len) n_unstable++;
      end
      if (phase == 1) begin
        if (k == 0) begin
          line_ack = 1'b1; phase = 2; k = d; rel_wait = rel + 1;
        end else begin
          k--;
          line_done = 1'($urandom_range(0, 1));
          line_err  = 1'($urandom_range(0, 1));
        end
      end
      if (abort_rel >= 0 && rel == abort_rel - 1) start = 1'b1;
      if (abort_rel >= 0 && rel == abort_rel) abort = 1'b1;
      // Scramble the live config to prove the job only uses its snapshot.
      cfg_width = 12'($urandom); cfg_height = 12'($urandom); cfg_stride = 12'($urandom);
      cfg_src_base = $urandom; cfg_dst_base = $urandom; cfg_timeout = 16'($urandom);
      tick();
      rel++;
    end
    line_ack = 0; line_done = 0; line_err = 0; abort = 0; start = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (line_req !== 1'b0) begin n_errors++; $display("FAIL reset_line_req got=%b exp=0", line_req); end
    n_checks++; if ({dsqw_done, err_size, mem_acc_err} !== 3'b000) begin
      n_errors++; $display("FAIL reset_pulses got=%b exp=000", {dsqw_done, err_size, mem_acc_err}); end
    n_checks++; if ({line_src_addr, line_dst_addr, line_len} !== 76'd0) begin
      n_errors++; $display("FAIL reset_addr got=%h/%h/%h exp=0", line_src_addr, line_dst_addr, line_len); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_legal_job();
    run_job(64, 3, 128, 32'h1000, 32'h8000, 16'd0, 1, 5, -1, -1, 3000);
    n_checks++; if (obs_src.size() !== 3) begin n_errors++; $display("FAIL legal_nreq got=%0d exp=3", obs_src.size()); end
    for (int i = 0; i < obs_src.size() && i < 3; i++) begin
      n_checks++;
      if (obs_src[i] !== 32'h1000 + 32'(i) * 32'h80 || obs_dst[i] !== 32'h8000 + 32'(i) * 32'h80 ||
          obs_len[i] !== 12'd64) begin
        n_errors++; $display("FAIL legal_req%0d got=%h/%h/%0d exp=%h/%h/64", i, obs_src[i], obs_dst[i],
                             obs_len[i], 32'h1000 + 32'(i) * 32'h80, 32'h8000 + 32'(i) * 32'h80);
      end
    end
    n_checks++; if (n_done !== 1 || rel_done !== 1 + 3 * (1 + 5 + 3)) begin
      n_errors++; $display("FAIL legal_done got=%0d@%0d exp=1@%0d", n_done, rel_done, 1 + 3 * 9); end
    n_checks++; if (rel_idle !== rel_done + 1) begin
      n_errors++; $display("FAIL legal_busy_drop got=%0d exp=%0d", rel_idle, rel_done + 1); end
    n_checks++; if (job_timeout !== 1'b0) begin n_errors++; $display("FAIL legal_hang got=%b exp=0", job_timeout); end
  endtask

  task automatic test_size_faults();
    int tw[6] = '{0, 64, 200, 64, 2049, 2048};
    int th[6] = '{4, 2049, 2, 0, 1, 1};
    int ts[6] = '{128, 128, 100, 128, 4095, 2048};
    for (int i = 0; i < 6; i++) begin
      bit f;
      f = exp_fault(tw[i], th[i], ts[i]);
      run_job(tw[i], th[i], ts[i], $urandom, $urandom, 16'd0, 0, 0, -1, -1, 3000);
      if (f) begin
        n_checks++; if (n_esize !== 1 || rel_esize !== 1) begin
          n_errors++; $display("FAIL size%0d_pulse got=%0d@%0d exp=1@1", i, n_esize, rel_esize); end
        n_checks++; if (n_req_cycles !== 0 || rel_idle !== 2) begin
          n_errors++; $display("FAIL size%0d_req_idle got=%0d/%0d exp=0/2", i, n_req_cycles, rel_idle); end
      end else begin
        n_checks++; if (n_esize !== 0 || n_done !== 1 || rel_done !== 1 + th[i] * 3) begin
          n_errors++; $display("FAIL size%0d_legal got=%0d/%0d@%0d exp=0/1@%0d", i, n_esize, n_done,
                               rel_done, 1 + th[i] * 3); end
      end
    end
  endtask

  task automatic test_line_err();
    run_job(32, 4, 64, 32'h2000, 32'h9000, 16'd0, 2, 3, 1, -1, 3000);
    n_checks++; if (obs_src.size() !== 2) begin n_errors++; $display("FAIL lerr_nreq got=%0d exp=2", obs_src.size()); end
    n_checks++; if (n_merr !== 1 || n_done !== 0 || rel_merr !== 1 * 8 + 8) begin
      n_errors++; $display("FAIL lerr_pulse got=merr%0d@%0d done%0d exp=merr1@16 done0", n_merr, rel_merr, n_done); end
  endtask

  task automatic test_timeout();
    run_job(32, 2, 64, 32'h0, 32'h100, 16'd10, 1, 50, -1, -1, 3000);
    n_checks++; if (n_merr !== 1 || n_done !== 0 || rel_merr !== 1 + 2 + 10) begin
      n_errors++; $display("FAIL tmo_fire got=merr%0d@%0d done%0d exp=merr1@13 done0", n_merr, rel_merr, n_done); end
    run_job(32, 1, 64, 32'h0, 32'h100, 16'd0, 0, 1000, -1, -1, 3000);
    n_checks++; if (n_merr !== 0 || n_done !== 1 || rel_done !== 1 + 1003) begin
      n_errors++; $display("FAIL tmo_off got=merr%0d done%0d@%0d exp=merr0 done1@1004", n_merr, n_done, rel_done); end
  endtask

  task automatic test_abort();
    run_job(16, 3, 16, 32'h4000, 32'h5000, 16'd0, 1, 20, -1, 6, 3000);
    n_checks++; if (rel_idle !== 7) begin n_errors++; $display("FAIL abort_idle got=%0d exp=7", rel_idle); end
    n_checks++; if (n_done + n_esize + n_merr !== 0 || obs_src.size() !== 1) begin
      n_errors++; $display("FAIL abort_pulses got=%0d pulses %0d reqs exp=0/1", n_done + n_esize + n_merr, obs_src.size()); end
    run_job(16, 3, 16, 32'h4000, 32'h5000, 16'd0, 0, 2, -1, -1, 3000);
    n_checks++; if (n_done !== 1 || obs_src.size() !== 3 || rel_done !== 1 + 3 * 5) begin
      n_errors++; $display("FAIL abort_rerun got=%0d/%0d@%0d exp=1/3@16", n_done, obs_src.size(), rel_done); end
  endtask

  task automatic test_addr_wrap();
    run_job(64, 2, 64, 32'hFFFF_FFC0, 32'h10, 16'd0, 0, 0, -1, -1, 3000);
    n_checks++; if (obs_src.size() !== 2 || obs_src[1] !== 32'h0 || obs_dst[1] !== 32'h50) begin
      n_errors++; $display("FAIL wrap_addr got=%0d/%h/%h exp=2/00000000/00000050", obs_src.size(),
                           (obs_src.size() > 1) ? obs_src[1] : 32'hx, (obs_dst.size() > 1) ? obs_dst[1] : 32'hx); end
    n_checks++; if (n_done !== 1 || rel_done !== 1 + 2 * 3) begin
      n_errors++; $display("FAIL wrap_done got=%0d@%0d exp=1@7", n_done, rel_done); end
  endtask

  task automatic test_reset_mid_job();
    cfg_width = 12'd8; cfg_height = 12'd2; cfg_stride = 12'd8;
    cfg_src_base = 32'hABC0; cfg_dst_base = 32'hDEF0; cfg_timeout = 16'd0;
    start = 1'b1; tick(); start = 1'b0; tick();
    n_checks++; if (line_req !== 1'b1) begin n_errors++; $display("FAIL midrst_pre got=%b exp=1", line_req); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, line_req} !== 2'b00 || line_src_addr !== 32'h0 || line_len !== 12'h0) begin
      n_errors++; $display("FAIL midrst_async got=%b%b/%h/%h exp=00/0/0", busy, line_req, line_src_addr, line_len); end
    tick(); tick();
    n_checks++; if ({dsqw_done, err_size, mem_acc_err, busy} !== 4'b0000) begin
      n_errors++; $display("FAIL midrst_quiet got=%b exp=0000", {dsqw_done, err_size, mem_acc_err, busy}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int j = 0; j < 25; j++) begin
      int w, h, s, a, d, e, sel, nl, exp_rel;
      logic [31:0] src, dst;
      logic [15:0] tmo;
      w = $urandom_range(1, 300); s = $urandom_range(w, 4095); h = $urandom_range(1, 5);
      sel = $urandom_range(0, 9);
      case (sel)
        0: w = 0;
        1: h = 0;
        2: begin w = $urandom_range(2049, 4095); s = 4095; end
        3: h = $urandom_range(2049, 4095);
        4: s = $urandom_range(0, w - 1);
        default: ;
      endcase
      a = $urandom_range(0, 3); d = $urandom_range(0, 6);
      e = (h > 0 && h <= 5 && $urandom_range(0, 3) == 0) ? $urandom_range(0, h - 1) : -1;
      tmo = ($urandom_range(0, 1) == 1) ? 16'd0 : 16'(d + 3 + $urandom_range(0, 20));
      src = $urandom; dst = $urandom;
      run_job(w, h, s, src, dst, tmo, a, d, e, -1, 3000);
      n_checks++; if (job_timeout !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_hang got=1 exp=0", j); end
      if (exp_fault(w, h, s)) begin
        n_checks++; if (n_esize !== 1 || rel_esize !== 1 || n_req_cycles !== 0 || n_done + n_merr !== 0) begin
          n_errors++; $display("FAIL rnd%0d_fault got=es%0d@%0d req%0d other%0d exp=es1@1 req0 other0",
                               j, n_esize, rel_esize, n_req_cycles, n_done + n_merr); end
      end else begin
        nl = (e >= 0) ? e + 1 : h;
        n_checks++; if (obs_src.size() !== nl) begin
          n_errors++; $display("FAIL rnd%0d_nreq got=%0d exp=%0d", j, obs_src.size(), nl); end
        for (int i = 0; i < obs_src.size() && i < nl; i++) begin
          n_checks++;
          if (obs_src[i] !== src + 32'(i) * 32'(s) || obs_dst[i] !== dst + 32'(i) * 32'(s) ||
              obs_len[i] !== 12'(w)) begin
            n_errors++; $display("FAIL rnd%0d_req%0d got=%h/%h/%0d exp=%h/%h/%0d", j, i, obs_src[i], obs_dst[i],
                                 obs_len[i], src + 32'(i) * 32'(s), dst + 32'(i) * 32'(s), w); end
        end
        if (e >= 0) begin
          exp_rel = e * (a + d + 3) + a + d + 3;
          n_checks++; if (n_merr !== 1 || rel_merr !== exp_rel || n_done !== 0) begin
            n_errors++; $display("FAIL rnd%0d_merr got=%0d@%0d done%0d exp=1@%0d done0", j, n_merr, rel_merr, n_done, exp_rel); end
        end else begin
          exp_rel = 1 + h * (a + d + 3);
          n_checks++; if (n_done !== 1 || rel_done !== exp_rel || n_merr !== 0) begin
            n_errors++; $display("FAIL rnd%0d_done got=%0d@%0d merr%0d exp=1@%0d merr0", j, n_done, rel_done, n_merr, exp_rel); end
        end
        n_checks++; if (rel_idle !== exp_rel + 1 || n_unstable !== 0 || n_b2b !== 0) begin
          n_errors++; $display("FAIL rnd%0d_proto got=idle%0d unstable%0d b2b%0d exp=idle%0d 0 0",
                               j, rel_idle, n_unstable, n_b2b, exp_rel + 1); end
      end
    end
  endtask

  initial begin
    start = 0; abort = 0; line_ack = 0; line_done = 0; line_err = 0;
    cfg_width = '0; cfg_height = '0; cfg_stride = '0;
    cfg_src_base = '0; cfg_dst_base = '0; cfg_timeout = '0;
    test_reset();
    test_legal_job();
    test_size_faults();
    test_line_err();
    test_timeout();
    test_abort();
    test_addr_wrap();
    test_reset_mid_job();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
